// File: rtl/stream_demux.sv
// Header-routed demux: strips one header word, forwards len payload words to out[dest] (optional DEMUX_PKT_COUNT_EN).
// Latency: payload accept -> out_valid on the next cycle, sustained 1 word/cycle.
// Backpressure: held word stays stable until out_ready[dest]; input stalls only while forwarding into a full stage.
module stream_demux #(
    parameter int NUM_OUTPUTS   = 8,
    parameter int WIDTH_OUTPUTS = 32,
    parameter int LEN_BITS      = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [WIDTH_OUTPUTS-1:0]                  in_data,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [NUM_OUTPUTS-1:0][WIDTH_OUTPUTS-1:0] out_data,
    output logic [NUM_OUTPUTS-1:0]                    out_valid,
    input  logic [NUM_OUTPUTS-1:0]                    out_ready,
`ifdef DEMUX_PKT_COUNT_EN
    output logic [NUM_OUTPUTS-1:0][15:0]              pkt_count,
`endif
    output logic                                      busy
);
    localparam int SEL_W = $clog2(NUM_OUTPUTS);

    typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;

    state_t              state;
    logic [SEL_W-1:0]    pkt_dest;
    logic [SEL_W-1:0]    dest_q;
    logic [LEN_BITS-1:0] remaining;
    logic [WIDTH_OUTPUTS-1:0] data_q;
    logic                valid_q;

    logic [SEL_W-1:0]    hdr_dest;
    logic [LEN_BITS-1:0] hdr_len;
    logic                hdr_ok;
    logic                sel_rdy;
    logic                accept;

    assign hdr_dest = in_data[SEL_W-1:0];
    assign hdr_len  = in_data[SEL_W+LEN_BITS-1:SEL_W];
    assign hdr_ok   = int'(hdr_dest) < NUM_OUTPUTS;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE) || valid_q;

    // Ready of the sink that owns the held word (dest_q, not the FSM's current header dest).
    always_comb begin
        sel_rdy = 1'b0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (dest_q == SEL_W'(i)) sel_rdy = out_ready[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            out_data[i]  = data_q;
            out_valid[i] = valid_q && (dest_q == SEL_W'(i));
        end
    end

    always_comb begin
        in_ready = 1'b1;
        if (state == FORWARD) in_ready = !valid_q || sel_rdy;
        if (rst)              in_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pkt_dest  <= '0;
            dest_q    <= '0;
            remaining <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (valid_q && sel_rdy) valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && hdr_len != '0) begin
                        remaining <= hdr_len;
                        pkt_dest  <= hdr_dest;
                        state     <= hdr_ok ? FORWARD : DROP;
                    end
                end
                FORWARD: begin
                    if (accept) begin
                        data_q    <= in_data;
                        valid_q   <= 1'b1;
                        dest_q    <= pkt_dest;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_BITS'(1)) state <= IDLE;
                    end
                end
                DROP: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_BITS'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DEMUX_PKT_COUNT_EN
    // Headers with a routable dest count, including zero-length ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (state == IDLE && accept && hdr_ok) begin
            pkt_count[hdr_dest] <= pkt_count[hdr_dest] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux (6 outputs) with a packet-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_stream_demux;
    localparam int N = 6;
    localparam int W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [W-1:0]        in_data;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0][W-1:0] out_data;
    logic [N-1:0]        out_valid;
    logic [N-1:0]        out_ready;
    logic                busy;
`ifdef DEMUX_PKT_COUNT_EN
    logic [N-1:0][15:0]  pkt_count;
`endif

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    stream_demux #(.NUM_OUTPUTS(N), .WIDTH_OUTPUTS(W), .LEN_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DEMUX_PKT_COUNT_EN
        .pkt_count(pkt_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Reference model: packet parser state after the next edge plus the words owed to sinks.
    typedef struct { int chan; logic [W-1:0] data; } exp_t;
    exp_t q[$];
    int   rem = 0;
    bit   fwd = 1'b0;
    int   cur = 0;
    logic [15:0] cnt [N];
    initial for (int i = 0; i < N; i++) cnt[i] = 16'd0;

    always @(negedge clk) begin : model
        logic [N-1:0] ev;
        bit   er;
        int   d;
        exp_t e;
        ev = '0;
        if (q.size() != 0) ev[q[0].chan] = 1'b1;
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (q.size() != 0) chk("out_data", 64'(out_data[q[0].chan]), 64'(q[0].data));
        chk("busy", 64'(busy), 64'(rem != 0 || q.size() != 0));
        er = !rst && !(rem != 0 && fwd && q.size() != 0 && !out_ready[q[0].chan]);
        chk("in_ready", 64'(in_ready), 64'(er));
`ifdef DEMUX_PKT_COUNT_EN
        for (int i = 0; i < N; i++) chk("pkt_count", 64'(pkt_count[i]), 64'(cnt[i]));
`endif
        if (rst) begin
            rem = 0;
            fwd = 1'b0;
            q.delete();
            for (int i = 0; i < N; i++) cnt[i] = 16'd0;
        end else begin
            if (q.size() != 0 && out_ready[q[0].chan]) void'(q.pop_front());
            if (in_valid && er) begin
                if (rem == 0) begin
                    d   = int'(in_data[2:0]);
                    rem = int'(in_data[10:3]);
                    fwd = (d < N);
                    cur = d;
                    if (d < N) cnt[d] = cnt[d] + 16'd1;
                end else begin
                    if (fwd) begin
                        e.chan = cur;
                        e.data = in_data;
                        q.push_back(e);
                    end
                    rem--;
                end
            end
        end
    end

    function automatic logic [W-1:0] hdr(input int dest, input int len);
        return 32'hA5000000 | (32'(len) << 3) | 32'(dest);
    endfunction

    task automatic send(input logic [W-1:0] w);
        bit acc;
        int n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            total++;
            $display("FAIL send_timeout: word %0h in_ready=%0b, required 1", w, in_ready);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = '1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        step();
        step();
        rst = 1'b0;

        // 1: dest=3 len=4, sinks always ready
        send(hdr(3, 4));
        send(32'h0000000A); send(32'h0000000B); send(32'h0000000C); send(32'h0000000D);
        idle();
        @(negedge clk);
        chk("t1_last_valid", 64'(out_valid), 64'b001000);
        chk("t1_last_data", 64'(out_data[3]), 64'h0000000D);
        chk("t1_busy_held", 64'(busy), 64'h1);
        step();
        @(negedge clk);
        chk("t1_drained", 64'(out_valid), 64'h0);
        chk("t1_busy_fall", 64'(busy), 64'h0);
        step();

        // 2: channel 3 stalls for 5 cycles after the first word
        out_ready = 6'b110111;
        send(hdr(3, 4));
        send(32'h1111000A);
        fork
            begin
                send(32'h1111000B); send(32'h1111000C); send(32'h1111000D);
            end
            begin
                repeat (2) @(negedge clk);
                chk("t2_stall_ready", 64'(in_ready), 64'h0);
                chk("t2_hold_valid", 64'(out_valid), 64'b001000);
                chk("t2_hold_data", 64'(out_data[3]), 64'h1111000A);
                repeat (4) @(posedge clk);
                #1;
                out_ready = '1;
            end
        join
        idle();
        step(); step();

        // 3: invalid dest is swallowed, next packet routes normally
        send(hdr(7, 3));
        send(32'h22220001);
        idle();
        @(negedge clk);
        chk("t3_drop_busy", 64'(busy), 64'h1);
        chk("t3_drop_valid", 64'(out_valid), 64'h0);
        step();
        send(32'h22220002); send(32'h22220003);
        send(hdr(0, 1));
        send(32'h22220004);
        idle();
        @(negedge clk);
        chk("t3_route0", 64'(out_valid), 64'b000001);
        chk("t3_route0_data", 64'(out_data[0]), 64'h22220004);
        step();

        // 4: zero-length packet
        send(hdr(2, 0));
        idle();
        @(negedge clk);
        chk("t4_busy", 64'(busy), 64'h0);
        chk("t4_valid", 64'(out_valid), 64'h0);
`ifdef DEMUX_PKT_COUNT_EN
        chk("t4_count", 64'(pkt_count[2]), 64'h1);
`endif
        step();

        // 5: reset mid-packet
        send(hdr(4, 4));
        send(32'h33330001); send(32'h33330002);
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_ready", 64'(in_ready), 64'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_after_rst_valid", 64'(out_valid), 64'h0);
        chk("t5_after_rst_busy", 64'(busy), 64'h0);
        step();
        send(hdr(1, 1));
        send(32'h33330003);
        idle();
        @(negedge clk);
        chk("t5_reparse", 64'(out_valid), 64'b000010);
        step();

        // 6: back-to-back packets, only the headers cost a cycle
        c0 = cyc;
        send(hdr(1, 2)); send(32'h44440001); send(32'h44440002);
        send(hdr(5, 2)); send(32'h44440005); send(32'h44440006);
        chk("t6_cycles", 64'(cyc - c0), 64'd6);
        idle();
        step(); step();

`ifdef DEMUX_PKT_COUNT_EN
        force dut.pkt_count = {16'd0, 16'd0, 16'd0, 16'hFFFF, 16'd0, 16'd0};
        cnt[0] = 16'd0; cnt[1] = 16'd0; cnt[2] = 16'hFFFF;
        cnt[3] = 16'd0; cnt[4] = 16'd0; cnt[5] = 16'd0;
        step();
        release dut.pkt_count;
        send(hdr(2, 0));
        idle();
        @(negedge clk);
        chk("t6_wrap", 64'(pkt_count[2]), 64'h0);
        step();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
